prog_mem_loader: RTL

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/bip_pkg.sv | 10 +
 rtl/prog_mem_ram.sv | 19 +
 rtl/prog_mem_loader.sv | 103 ++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared definitions for the program-memory loader: FSM states and opcode/byte constants.
package bip_pkg;
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int BYTE_W  = 8;
  localparam int HALT_OP = 0;
endpackage

// File: rtl/prog_mem_ram.sv
// Synchronous single-port program RAM with a registered read port.
module prog_mem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/prog_mem_loader.sv
// Byte-serial program loader: assembles little-endian words into RAM, then serves CPU fetches.
module prog_mem_loader
  import bip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              run,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow
);
  localparam int NB  = DATA_W / BYTE_W;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state, nstate;
  logic [BIW-1:0]    bidx;
  logic [DATA_W-1:0] asm_q, wdata, rdata;
  logic [ADDR_W:0]   wr_ptr;
  logic              overflow_q, rd_vld, halt_q;
  logic              acc, word_done, full, clr, ram_we;
  logic [AW-1:0]     ram_addr;

  assign acc       = ld_valid & ld_ready;
  assign word_done = acc & ((bidx == BIW'(NB - 1)) | ld_last);
  assign full      = (wr_ptr == (ADDR_W + 1)'(DEPTH));
  assign clr       = !rst || (state == RUN && reload);
  // Bytes above bidx are always zero in asm_q, so a short final word is zero-padded for free.
  assign wdata     = asm_q | (DATA_W'(ld_byte) << (BYTE_W * bidx));

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      LOAD: if (acc && ld_last) nstate = RUN;
      RUN:  if (reload)         nstate = LOAD;
      default:                  nstate = LOAD;
    endcase
  end

  always_comb begin
    ld_ready = rst && (state == LOAD);
    run      = rst && (state == RUN);
    ram_we   = word_done && !full;
    ram_addr = (state == RUN) ? address[AW-1:0] : wr_ptr[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bidx       <= '0;
      asm_q      <= '0;
      wr_ptr     <= '0;
      overflow_q <= 1'b0;
    end else if (acc) begin
      if (word_done) begin
        bidx  <= '0;
        asm_q <= '0;
        if (!full) wr_ptr     <= wr_ptr + 1'b1;
        else       overflow_q <= 1'b1;
      end else begin
        bidx  <= bidx + 1'b1;
        asm_q <= wdata;
      end
    end
  end

  // Read-side qualifiers travel alongside the RAM's registered output.
  always_ff @(posedge clk) begin
    rd_vld <= rst && (state == RUN) && !reload;
    halt_q <= ({1'b0, address} >= wr_ptr);
  end

  prog_mem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_comb begin
    if (!run || !rd_vld) data = '1;
    else if (halt_q)     data = DATA_W'(HALT_OP);
    else                 data = rdata;
  end

  assign prog_len = wr_ptr;
  assign overflow = overflow_q;
endmodule
